// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types, constants and round-robin helper for the RLE frame arbiter
package rle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    GAP
  } arb_state_t;

  localparam int FLUSH_PULSE_W = 1;
  localparam int RR_MAX        = 8;

  // First set request after 'last', wrapping modulo n; keeps 'last' when nothing is requesting.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        last,
                                         input int                n);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = last;
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = 3'((int'(last) + k) % n);
        if (req[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rle_rr_picker.sv
// rtl/rle_rr_picker.sv - combinational round-robin priority picker
module rle_rr_picker
  import rle_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   last,
  output logic [SRC_W-1:0]   pick,
  output logic               any
);

  logic [RR_MAX-1:0] req_ext;
  logic [2:0]        last_ext;
  logic [2:0]        pick_ext;

  // Widen to the helper's fixed width and search from the slot after the previous owner.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    last_ext               = 3'(last);
    pick_ext               = rr_pick(req_ext, last_ext, NUM_REQ);
    pick                   = SRC_W'(pick_ext);
    any                    = |req;
  end

endmodule

// File: rtl/rle_frame_arbiter.sv
// rtl/rle_frame_arbiter.sv - round-robin frame arbiter feeding the shared RLE compressor
module rle_frame_arbiter
  import rle_pkg::*;
#(
  parameter int  NUM_REQ       = 4,
  parameter int  LEN_W         = 16,
  parameter int  STALL_TIMEOUT = 16,
  parameter int  GAP_CYCLES    = 1,
  localparam int SRC_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           data_in,
  output logic                 valid_in,
  output logic                 cmp_flush,
  output logic [SRC_W-1:0]     cmp_src,
  output logic                 frame_done,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int STALL_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  arb_state_t               state, state_nxt;
  logic [SRC_W-1:0]         grant, last_grant, pick;
  logic                     any;
  logic [STALL_W-1:0]       stall_cnt, stall_nxt;
  logic [GAP_W-1:0]         gap_cnt;
  logic [LEN_W-1:0]         len_cnt;
  logic                     abort;
  logic                     xfer, stall_hit;
  logic                     sel_valid, sel_last;
  logic [7:0]               sel_data;
  logic [FLUSH_PULSE_W-1:0] flush_q;

  assign cmp_flush = flush_q[0];

  rle_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_picker (
    .req  (req_valid),
    .last (last_grant),
    .pick (pick),
    .any  (any)
  );

  // Owner's lane select and ready; ready depends only on state and grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == SRC_W'(i)) begin
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[8*i +: 8];
        req_ready[i] = (state == STREAM);
      end
    end
  end

  // Next-state logic: frame ends on a last-byte transfer or when the owner idles too long.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    xfer      = 1'b0;
    stall_hit = 1'b0;
    stall_nxt = stall_cnt;
    case (state)
      IDLE:   if (any) state_nxt = STREAM;
      STREAM: begin
        xfer      = sel_valid;
        stall_nxt = xfer ? '0 : stall_cnt + STALL_W'(1);
        stall_hit = (STALL_TIMEOUT != 0) && !xfer && (stall_nxt == STALL_W'(STALL_TIMEOUT));
        if ((xfer && sel_last) || stall_hit) state_nxt = FLUSH;
      end
      FLUSH:  state_nxt = GAP;
      GAP:    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant capture, byte forwarding, frame counters and end-of-frame pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      last_grant  <= SRC_W'(NUM_REQ - 1);
      cmp_src     <= '0;
      data_in     <= '0;
      valid_in    <= 1'b0;
      flush_q     <= '0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      timeout_err <= 1'b0;
      stall_cnt   <= '0;
      gap_cnt     <= '0;
      len_cnt     <= '0;
      abort       <= 1'b0;
    end else begin
      valid_in    <= xfer;
      flush_q     <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      if (xfer) data_in <= sel_data;
      case (state)
        IDLE: begin
          if (any) begin
            grant      <= pick;
            last_grant <= pick;
            cmp_src    <= pick;
            stall_cnt  <= '0;
          end
        end
        STREAM: begin
          stall_cnt <= stall_nxt;
          if (xfer && (len_cnt != LEN_MAX)) len_cnt <= len_cnt + LEN_W'(1);
          if (stall_hit) abort <= 1'b1;
        end
        FLUSH: begin
          flush_q     <= '1;
          frame_done  <= 1'b1;
          frame_len   <= len_cnt;
          timeout_err <= abort;
          len_cnt     <= '0;
          abort       <= 1'b0;
          stall_cnt   <= '0;
          gap_cnt     <= '0;
        end
        GAP:     gap_cnt <= gap_cnt + GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule
